// File: rtl/lsu_mem_bank_if.sv
// Request/response signal bundle between the LSU and a scratchpad bank.
// master = LSU side, slave = bank side.
interface lsu_mem_bank_if;
  logic [42:0] lsu_bus;
  logic        clear_req;
  logic [32:0] bank_readin_bus;
  logic        bank_busy;
  logic        req_drop;
  logic        oor_err;

  modport master (
    output lsu_bus, clear_req,
    input  bank_readin_bus, bank_busy, req_drop, oor_err
  );

  modport slave (
    input  lsu_bus, clear_req,
    output bank_readin_bus, bank_busy, req_drop, oor_err
  );
endinterface

// File: rtl/lsu_mem_bank.sv
// Scratchpad bank behind the LSU request bus with an RD_LAT-deep read pipeline.
// Define MEM_BANK_CLEAR_EN to build the clear engine (auto-clear after reset, clear_req).
module lsu_mem_bank #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned RD_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_bank_if.slave bus
);
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [9:0]  DEPTH_W = 10'(DEPTH);

  if (DEPTH < 1 || DEPTH > 512 || RD_LAT < 1 || RD_LAT > 4) begin : g_bad_param
    $error("lsu_mem_bank: DEPTH must be 1..512 and RD_LAT 1..4");
  end

  logic          req_vld;
  logic          req_we;
  logic [8:0]    req_addr;
  logic [31:0]   req_wdata;
  logic          addr_ok;
  logic          accept;
  logic          serve;
  logic          rd_fire;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   rd_data;
  logic [31:0]   mem_q [DEPTH];
  logic          oor_q;
  logic          vld_q [RD_LAT];
  logic [31:0]   dat_q [RD_LAT];

  assign req_vld   = bus.lsu_bus[42];
  assign req_we    = bus.lsu_bus[41];
  assign req_addr  = bus.lsu_bus[40:32];
  assign req_wdata = bus.lsu_bus[31:0];
  assign addr_ok   = ({1'b0, req_addr} < DEPTH_W);

`ifdef MEM_BANK_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;
  logic          drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.clear_req) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          // Requests arriving mid-clear are discarded; clear_req here is ignored.
          if (req_vld) drop_q <= 1'b1;
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign accept        = (state_q == S_IDLE);
  assign clr_we        = (state_q == S_CLEAR);
  assign clr_addr      = cnt_q;
  assign bus.bank_busy = busy_q;
  assign bus.req_drop  = drop_q;
`else
  logic unused_clear_req;

  assign unused_clear_req = bus.clear_req;
  assign accept           = 1'b1;
  assign clr_we           = 1'b0;
  assign clr_addr         = '0;
  assign bus.bank_busy    = 1'b0;
  assign bus.req_drop     = 1'b0;
`endif

  assign serve   = req_vld & accept;
  assign rd_fire = serve & ~req_we;

  // The clear engine owns the single write port while active; requests cannot be served then.
  assign mem_we    = clr_we | (serve & req_we & addr_ok);
  assign mem_waddr = clr_we ? clr_addr : req_addr[AW-1:0];
  assign mem_wdata = clr_we ? '0 : req_wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Out-of-range reads still respond, with zero data.
  assign rd_data = addr_ok ? mem_q[req_addr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oor_q <= 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_fire;
      dat_q[0] <= rd_fire ? rd_data : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
      if (serve && !addr_ok) oor_q <= 1'b1;
    end
  end

  assign bus.bank_readin_bus = {vld_q[RD_LAT-1], dat_q[RD_LAT-1]};
  assign bus.oor_err         = oor_q;
endmodule

// File: tb/tb_lsu_mem_bank.sv
// Bench for lsu_mem_bank: directed steps plus random traffic against a cycle-level bank model.
module tb_lsu_mem_bank;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned RD_LAT = 3;
`ifdef MEM_BANK_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_bank_if bif ();

  lsu_mem_bank #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // Model state: memory image, which words hold defined data, clear progress, sticky flags.
  logic [31:0] m_mem   [512];
  bit          m_known [512];
  int          m_clr_left;
  bit          m_drop;
  bit          m_oor;
  // Expected responses, indexed by the cycle in which they must appear (mod 8).
  bit          e_v [8];
  bit          e_k [8];
  logic [31:0] e_d [8];
  int          cyc;
  int          n_tests;
  int          n_fail;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle(input bit v, input bit we, input logic [8:0] a,
                       input logic [31:0] d, input bit clr);
    int s;
    int ca;
    bif.lsu_bus   = {v, we, a, d};
    bif.clear_req = clr;
    @(negedge clk);
    s = cyc % 8;
    chk("rsp_valid", {32'b0, bif.bank_readin_bus[32]}, {32'b0, e_v[s]});
    if (e_v[s] && e_k[s]) chk("rsp_data", bif.bank_readin_bus, {1'b1, e_d[s]});
    e_v[s] = 1'b0;
    chk("busy", {32'b0, bif.bank_busy}, {32'b0, (m_clr_left > 0)});
    chk("req_drop", {32'b0, bif.req_drop}, {32'b0, m_drop});
    chk("oor_err", {32'b0, bif.oor_err}, {32'b0, m_oor});
    if (m_clr_left > 0) begin
      ca = DEPTH - m_clr_left;
      m_mem[ca]   = '0;
      m_known[ca] = 1'b1;
      m_clr_left--;
      if (v) m_drop = 1'b1;
    end else begin
      if (v) begin
        if (a >= DEPTH) m_oor = 1'b1;
        if (we) begin
          if (a < DEPTH) begin
            m_mem[a]   = d;
            m_known[a] = 1'b1;
          end
        end else begin
          s = (cyc + RD_LAT) % 8;
          e_v[s] = 1'b1;
          e_k[s] = (a >= DEPTH) || m_known[a];
          e_d[s] = (a < DEPTH) ? m_mem[a] : 32'h0;
        end
      end
      if (clr && CLR_EN) m_clr_left = DEPTH;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 9'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset(input int hold);
    rst           = 1'b0;
    bif.lsu_bus   = '0;
    bif.clear_req = 1'b0;
    #1;
    chk("rst_bus", bif.bank_readin_bus, 33'h0);
    chk("rst_drop", {32'b0, bif.req_drop}, 33'h0);
    chk("rst_oor", {32'b0, bif.oor_err}, 33'h0);
    chk("rst_busy", {32'b0, bif.bank_busy}, {32'b0, CLR_EN});
    for (int i = 0; i < 8; i++) e_v[i] = 1'b0;
    m_drop     = 1'b0;
    m_oor      = 1'b0;
    m_clr_left = CLR_EN ? DEPTH : 0;
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic random_phase(input int n);
    bit          v;
    bit          we;
    bit          clr;
    logic [8:0]  a;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      v   = ($urandom_range(0, 9) < 7);
      we  = $urandom_range(0, 1) == 1;
      a   = 9'($urandom_range(0, DEPTH + 15));
      d   = $urandom;
      clr = ($urandom_range(0, 149) == 0);
      cycle(v, we, a, d, clr);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    bif.lsu_bus   = '0;
    bif.clear_req = 1'b0;
    #2;
    do_reset(2);
    idle(DEPTH + 2);
    cycle(1'b1, 1'b0, 9'(DEPTH - 1), 32'h0, 1'b0);
    idle(RD_LAT + 1);

    // Read-after-write with RD_LAT latency.
    cycle(1'b1, 1'b1, 9'd5, 32'hDEADBEEF, 1'b0);
    cycle(1'b1, 1'b0, 9'd5, 32'h0, 1'b0);
    idle(RD_LAT + 2);

    // Back-to-back pipelined reads.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 9'(i), 32'(i * 32'h11), 1'b0);
    for (int i = 4; i >= 1; i--) cycle(1'b1, 1'b0, 9'(i), 32'h0, 1'b0);
    idle(RD_LAT + 2);

    // Out-of-range write and read, then in-range word 0.
    cycle(1'b1, 1'b1, 9'h100, 32'h55, 1'b0);
    cycle(1'b1, 1'b0, 9'h100, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 9'h000, 32'h0, 1'b0);
    idle(RD_LAT + 2);

    // Write dropped on the second busy cycle of a clear.
    cycle(1'b0, 1'b0, 9'h0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 9'h0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 9'd7, 32'hAA, 1'b0);
    idle(DEPTH);
    cycle(1'b1, 1'b0, 9'd7, 32'h0, 1'b0);
    idle(RD_LAT + 2);

    // Reads in flight as a clear starts; clear_req with a request in the same cycle.
    cycle(1'b1, 1'b1, 9'd9, 32'h12345678, 1'b0);
    cycle(1'b1, 1'b0, 9'd5, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 9'd9, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 9'd3, 32'h77, 1'b1);
    idle(DEPTH + 2);

    random_phase(700);

    // Reset with two reads in flight.
    idle(RD_LAT + 2);
    cycle(1'b1, 1'b1, 9'h120, 32'h1, 1'b0);
    cycle(1'b1, 1'b0, 9'd2, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 9'd3, 32'h0, 1'b0);
    do_reset(3);
    idle(DEPTH + 4);

    // Reset while the clear counter sits at 100.
    cycle(1'b0, 1'b0, 9'h0, 32'h0, 1'b1);
    idle(100);
    do_reset(2);
    idle(DEPTH + 4);

    random_phase(300);
    idle(RD_LAT + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_mem_bank.md
Name: lsu_mem_bank

Overview:
- Scratchpad memory bank that sits on the far end of the LSU request bus.
- Accepts one read or write request per cycle on the 43-bit request bus.
- Returns read data on the 33-bit bank read-in bus after a fixed, parameterised latency.
- Provides post-reset / on-demand memory clearing plus sticky error flags for the CGRA controller.

Parameters:
- DEPTH, 512: number of 32-bit words; must be 1..512, since the 9-bit address field is fixed by the bus format.
- RD_LAT, 1: read latency in cycles from request to response; legal range 1..4.

Ports:
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: reset, asynchronous and active-low.
- lsu_bus  input  43: request bus. [42] valid, [41] write enable, [40:32] word address, [31:0] write data.
- clear_req  input  1: single-cycle pulse that starts a memory clear.
- bank_readin_bus  output  33: response bus. [32] valid, [31:0] read data.
- bank_busy  output  1: high while a clear is in progress.
- req_drop  output  1: sticky flag; a request arrived while busy.
- oor_err  output  1: sticky flag; a request address was >= DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - bank_readin_bus=0, req_drop=0, oor_err=0, read pipeline emptied, clear counter=0.
  - With MEM_BANK_CLEAR_EN defined: state goes to CLEAR and bank_busy=1. Without it: state goes to IDLE and bank_busy=0.
  - Memory contents are not touched by reset itself.
- Request decode: a request is valid in cycle N when lsu_bus[42]=1 and state is IDLE.
- Write (we=1):
  - mem[addr] <= wdata at the end of cycle N.
  - No response is generated.
- Read (we=0):
  - bank_readin_bus = {1'b1, mem[addr]} in cycle N+RD_LAT, then returns to valid=0 unless another read is pipelined behind it.
  - Back-to-back reads are fully pipelined, one response per cycle, in request order.
- Read-after-write: a write in cycle N followed by a read of the same address in cycle N+1 returns the new data. No same-cycle hazard exists because only one request is possible per cycle.
- Out-of-range address (addr >= DEPTH):
  - Write: ignored.
  - Read: still produces a response, valid=1 with data=0.
  - Either case sets oor_err=1.
- Responses are never stalled; the bank has no backpressure.
- The valid bit is shifted through an RD_LAT-deep pipeline alongside the data.
- Bus bits [31:0] are don't-care on reads; bit [41] is ignored when [42]=0.
- FSM states:
  - IDLE: serves requests. clear_req=1 -> CLEAR, counter=0, bank_busy=1 from the next cycle.
  - CLEAR: writes mem[counter]=0 and increments counter once per cycle. Leaves CLEAR after the cycle in which counter = DEPTH-1, so the clear lasts exactly DEPTH cycles. bank_busy=0 in the first IDLE cycle.
- Boundary cases:
  - Request seen in CLEAR: dropped with no memory effect and no response; req_drop=1.
  - clear_req in CLEAR: ignored; the counter does not restart.
  - Reads already in the pipeline when CLEAR starts still complete with their pre-clear data.
  - clear_req and a valid request in the same IDLE cycle: the request is served and CLEAR begins next cycle.
  - Reset mid-CLEAR: counter returns to 0 and, with MEM_BANK_CLEAR_EN defined, the clear restarts from address 0.
  - req_drop and oor_err clear only on reset.

Optional Feature:
- Macro: MEM_BANK_CLEAR_EN.
- Defined:
  - The CLEAR state and counter are built.
  - The bank auto-clears for DEPTH cycles after reset release.
  - clear_req is honoured.
- Not defined:
  - No CLEAR state or counter logic.
  - bank_busy and req_drop are tied 0 and clear_req is ignored.
  - Memory is uninitialised after reset and requests are served from the first cycle after reset release.

Test Plan:
- Clear on reset (macro defined, DEPTH=512): release rst -> bank_busy=1 for exactly 512 cycles, then 0. A subsequent read of addr 0x1FF returns {1,32'h0}.
- Write/read latency (RD_LAT=3): write 0xDEADBEEF to addr 5 in cycle T, read addr 5 in cycle T+1 -> bank_readin_bus=33'h1_DEADBEEF in cycle T+4 only, valid=0 in T+3 and T+5.
- Pipelined reads (RD_LAT=1): write addr 1..4 = 0x11,0x22,0x33,0x44, then 4 consecutive reads of addr 4,3,2,1 -> data 0x44,0x33,0x22,0x11 on 4 consecutive cycles.
- Drop during clear: pulse clear_req, then write 0xAA to addr 7 on the second busy cycle -> req_drop=1; after the clear, a read of addr 7 returns 0.
- Out of range (DEPTH=256): write 0x55 to addr 0x100 -> oor_err=1; read addr 0x100 -> response {1,32'h0}; read addr 0x000 is unaffected.
- Reset mid-operation: assert rst while 2 reads are in flight and CLEAR is at counter 100 -> bank_readin_bus=0 immediately and no stale responses appear after release. The clear restarts with a full 512-cycle busy period, and both flags are 0.
